// File: rtl/mips_muldiv_pkg.sv
// Shared multiply/divide encodings: op codes, FSM states and the per-op launch record.
// Imported by the muldiv unit, execute stage and hazard unit.
package mips_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CALC  = 2'd1,
    S_FIXUP = 2'd2
  } md_state_e;

  // Everything FIXUP needs to know about the op, captured at launch.
  typedef struct packed {
    logic is_div;
    logic neg_res;
    logic neg_rem;
    logic div_zero;
  } md_meta_t;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_sign_fix.sv
// Combinational conditional two's-complement negate, used for operand abs and result fixup.
// Zero latency; no flow control.
module muldiv_sign_fix #(
  parameter int W = 32
) (
  input  logic [W-1:0] val,
  input  logic         neg,
  output logic [W-1:0] res
);

  assign res = neg ? ('0 - val) : val;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 1-bit/cycle multiply/divide with HI/LO registers; latency WIDTH+2 clocks.
// No backpressure: start is ignored while busy, cancel aborts the in-flight op.
module muldiv_unit
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             cancel,
  input  logic             mthi_we,
  input  logic             mtlo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  md_state_e          state, state_nx;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   addend_q;
  md_meta_t           meta_q;

  logic               signed_op, launch;
  logic [WIDTH-1:0]   mag_a, mag_b;

  assign signed_op = SIGNED_EN && is_signed_op(op);
  assign launch    = (state == S_IDLE) && start && !cancel;

  muldiv_sign_fix #(.W(WIDTH)) u_abs_a (.val(src_a), .neg(signed_op && src_a[WIDTH-1]), .res(mag_a));
  muldiv_sign_fix #(.W(WIDTH)) u_abs_b (.val(src_b), .neg(signed_op && src_b[WIDTH-1]), .res(mag_b));

  // Multiply step: acc = {partial product, remaining multiplier bits}, shifting right.
  logic [WIDTH-1:0]   addend_sel;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_nx;

  assign addend_sel = acc[0] ? addend_q : '0;
  assign mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, addend_sel};
  assign mul_nx     = {mul_sum, acc[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend/quotient bits}, shifting left.
  logic [WIDTH:0]     trial;
  logic               q_ok;
  logic [WIDTH-1:0]   rem_nx;
  logic [2*WIDTH-1:0] div_nx;

  assign trial  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
  assign q_ok   = trial >= {1'b0, addend_q};
  assign rem_nx = q_ok ? WIDTH'(trial - {1'b0, addend_q}) : trial[WIDTH-1:0];
  assign div_nx = {rem_nx, acc[WIDTH-2:0], q_ok};

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  muldiv_sign_fix #(.W(2*WIDTH)) u_fix_prod (.val(acc), .neg(meta_q.neg_res), .res(prod_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_quo (.val(acc[WIDTH-1:0]), .neg(meta_q.neg_res), .res(quo_fix));
  muldiv_sign_fix #(.W(WIDTH)) u_fix_rem (.val(acc[2*WIDTH-1:WIDTH]), .neg(meta_q.neg_rem), .res(rem_fix));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != S_IDLE);
    unique case (state)
      S_IDLE:  if (start && !cancel) state_nx = S_CALC;
      S_CALC:  if (cancel) state_nx = S_IDLE;
               else if (cnt == '0) state_nx = S_FIXUP;
      S_FIXUP: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt      <= '0;
      acc      <= '0;
      addend_q <= '0;
      meta_q   <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done <= 1'b0;
      if (state == S_IDLE) begin
        if (mthi_we) hi <= wdata;
        if (mtlo_we) lo <= wdata;
      end
      if (launch) begin
        acc             <= is_div_op(op) ? {{WIDTH{1'b0}}, mag_a} : {{WIDTH{1'b0}}, mag_b};
        addend_q        <= is_div_op(op) ? mag_b : mag_a;
        meta_q.is_div   <= is_div_op(op);
        meta_q.neg_res  <= signed_op && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        meta_q.neg_rem  <= signed_op && src_a[WIDTH-1];
        meta_q.div_zero <= is_div_op(op) && (src_b == '0);
        cnt             <= CW'(WIDTH - 1);
        div_zero        <= 1'b0;
      end
      if (state == S_CALC && !cancel) begin
        acc <= meta_q.is_div ? div_nx : mul_nx;
        cnt <= cnt - CW'(1);
      end
      // Divide-by-zero: the restoring loop leaves |dividend| as remainder, so rem_fix
      // reproduces the launched src_a; only the quotient needs forcing.
      if (state == S_FIXUP && !cancel) begin
        done     <= 1'b1;
        div_zero <= meta_q.div_zero;
        if (!meta_q.is_div) begin
          hi <= prod_fix[2*WIDTH-1:WIDTH];
          lo <= prod_fix[WIDTH-1:0];
        end else begin
          hi <= rem_fix;
          lo <= meta_q.div_zero ? {WIDTH{1'b1}} : quo_fix;
        end
      end
    end
  end

endmodule
